usb_readback_merger: RTL and testbench

//  Read-return path of the AXI USB slave, the counterpart of the write-side data splitter.

---
 rtl/usb_rdbk_pkg.sv | 16 +
 rtl/usb_readback_merger_if.sv | 43 ++++
 rtl/usb_rdbk_timer.sv | 31 +++
 rtl/usb_readback_merger.sv | 144 ++++++++++++++
 tb/tb_usb_readback_merger.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rdbk_pkg.sv
// Shared types and constants for the USB read-return merger.
package usb_rdbk_pkg;

  localparam int RSP_W = 32;
  localparam logic [RSP_W-1:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    REG_RD,
    REG_WAIT,
    MEM_RD,
    MEM_WAIT,
    RESP
  } rdbk_state_t;

endpackage

// File: rtl/usb_readback_merger_if.sv
// Request, register-file, memory and response signals of the read-return path.
// The slave modport is the merger's view; master is the surrounding logic.
interface usb_readback_merger_if #(
  parameter int ADDR_W = 32,
  parameter int REG_AW = 8,
  parameter int MEM_W  = 32,
  parameter int REG_W  = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_reg_mem;
  logic [ADDR_W-1:0] req_addr;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid;
  logic [MEM_W-1:0]  mem_rd_data;

  logic              reg_rd_en;
  logic [REG_AW-1:0] reg_rd_addr;
  logic [REG_W-1:0]  reg_rd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_reg_mem, req_addr,
    input  mem_rd_valid, mem_rd_data, reg_rd_data, rsp_ready,
    output req_ready, mem_rd_en, mem_rd_addr, reg_rd_en, reg_rd_addr,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_reg_mem, req_addr,
    output mem_rd_valid, mem_rd_data, reg_rd_data, rsp_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, reg_rd_en, reg_rd_addr,
    input  rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/usb_rdbk_timer.sv
// MEM_WAIT timeout counter. The module only exists when USB_RDBK_TIMEOUT_EN is defined.
`ifdef USB_RDBK_TIMEOUT_EN
module usb_rdbk_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // expired marks the TIMEOUT_CYCLES-th enabled cycle; the counter parks there.
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/usb_readback_merger.sv
// Read-return path: one host read to register file or memory, zero-extended onto a
// valid/ready response. Define USB_RDBK_TIMEOUT_EN to enable the MEM_WAIT timeout.
module usb_readback_merger
  import usb_rdbk_pkg::*;
#(
  parameter int              ADDR_W         = 32,
  parameter int              REG_AW         = 8,
  parameter int              MEM_W          = 32,
  parameter int              REG_W          = 8,
  parameter int              TIMEOUT_CYCLES = 256,
  parameter logic [RSP_W-1:0] ERR_WORD      = ERR_WORD_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  usb_readback_merger_if.slave bus
);

  if (MEM_W > RSP_W || REG_W > RSP_W || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("usb_readback_merger: data widths must be <= 32 and TIMEOUT_CYCLES >= 1");
  end

  rdbk_state_t       state, state_nx;
  logic [RSP_W-1:0]  data_nx;
  logic              err_nx;
  logic              accept;
  logic              timed_out;

  logic              req_ready_q;
  logic              mem_rd_en_q;
  logic              reg_rd_en_q;
  logic              rsp_valid_q;
  logic [RSP_W-1:0]  rsp_data_q;
  logic              rsp_err_q;
  logic [ADDR_W-1:0] mem_rd_addr_q;
  logic [REG_AW-1:0] reg_rd_addr_q;

  assign accept = (state == IDLE) && bus.req_valid && req_ready_q;

`ifdef USB_RDBK_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;

  assign timer_clear  = (state == MEM_RD);
  assign timer_enable = (state == MEM_WAIT);

  usb_rdbk_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    state_nx = state;
    data_nx  = rsp_data_q;
    err_nx   = rsp_err_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = bus.req_reg_mem ? REG_RD : MEM_RD;
        end
      end
      REG_RD: state_nx = REG_WAIT;
      REG_WAIT: begin
        data_nx  = RSP_W'(bus.reg_rd_data);
        err_nx   = 1'b0;
        state_nx = RESP;
      end
      MEM_RD: state_nx = MEM_WAIT;
      MEM_WAIT: begin
        // Data arriving on the timeout cycle still wins over the error word.
        if (bus.mem_rd_valid) begin
          data_nx  = RSP_W'(bus.mem_rd_data);
          err_nx   = 1'b0;
          state_nx = RESP;
        end else if (timed_out) begin
          data_nx  = ERR_WORD;
          err_nx   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each strobe is a clean one-cycle flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      mem_rd_addr_q <= '0;
      reg_rd_addr_q <= '0;
    end else begin
      req_ready_q <= (state_nx == IDLE);
      reg_rd_en_q <= (state_nx == REG_RD);
      mem_rd_en_q <= (state_nx == MEM_RD);
      rsp_valid_q <= (state_nx == RESP);
      rsp_data_q  <= data_nx;
      rsp_err_q   <= err_nx;
      if (accept) begin
        if (bus.req_reg_mem) begin
          reg_rd_addr_q <= bus.req_addr[REG_AW-1:0];
        end else begin
          mem_rd_addr_q <= bus.req_addr;
        end
      end
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.reg_rd_en   = reg_rd_en_q;
  assign bus.reg_rd_addr = reg_rd_addr_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_usb_readback_merger.sv
// Randomised scoreboard bench for usb_readback_merger; covers the timeout path when
// USB_RDBK_TIMEOUT_EN is defined.
module tb_usb_readback_merger;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic        is_reg;
    logic [31:0] addr;
  } strobe_t;

  logic clk;
  logic rst;

  usb_readback_merger_if #(.ADDR_W(32), .REG_AW(8), .MEM_W(32), .REG_W(8)) bus ();

  usb_readback_merger #(
    .ADDR_W        (32),
    .REG_AW        (8),
    .MEM_W         (32),
    .REG_W         (8),
    .TIMEOUT_CYCLES(8),
    .ERR_WORD      (32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int      n_vec  = 0;
  int      n_miss = 0;
  rsp_t    exp_rsp[$];
  strobe_t exp_strobe[$];
  logic [7:0] regfile[256];
  int      mem_delay  = 1;
  int      ready_mode = 0;   // 0 always ready, 1 random, 2 held low
  bit      stray_req  = 0;
  int      rst_count  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural memory contents: a fixed word at 0x100, a hash of the address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFE_F00D;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},   32'(bus.req_ready),   32'd0);
    check({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
    check({tag, "_mem_rd_en"},   32'(bus.mem_rd_en),   32'd0);
    check({tag, "_reg_rd_en"},   32'(bus.reg_rd_en),   32'd0);
    check({tag, "_rsp_data"},    bus.rsp_data,         32'd0);
    check({tag, "_rsp_err"},     32'(bus.rsp_err),     32'd0);
    check({tag, "_mem_rd_addr"}, bus.mem_rd_addr,      32'd0);
    check({tag, "_reg_rd_addr"}, 32'(bus.reg_rd_addr), 32'd0);
  endtask

  // delay < 0: memory never answers in time (a late, ignored valid follows).
  task automatic issue(input bit is_reg, input logic [31:0] a, input int delay, input bit stray);
    int budget;
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_reg_mem = is_reg;
    bus.req_addr    = a;
    mem_delay       = delay;
    budget = 0;
    while (!bus.req_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.req_ready) begin
      check("req_accept", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    exp_strobe.push_back('{is_reg: is_reg, addr: a});
    if (is_reg)         exp_rsp.push_back('{data: {24'h0, regfile[a[7:0]]}, err: 1'b0});
    else if (delay < 0) exp_rsp.push_back('{data: 32'hDEAD_BEEF, err: 1'b1});
    else                exp_rsp.push_back('{data: mem_word(a), err: 1'b0});
    @(posedge clk);
    #1;
    bus.req_valid   = 1'b0;
    bus.req_addr    = $urandom;
    bus.req_reg_mem = 1'($urandom);
    if (stray) stray_req = 1'b1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_rsp.size() != 0 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check("drain_pending", 32'(exp_rsp.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // rsp_ready driver, updated just after the rising edge.
  initial begin : ready_driver
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Register file: data is valid exactly in the cycle after the strobe, garbage otherwise.
  initial begin : reg_model
    logic [7:0] ra;
    bus.reg_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.reg_rd_en) begin
        ra = bus.reg_rd_addr;
        @(posedge clk);
        #1 bus.reg_rd_data = regfile[ra];
        @(posedge clk);
        #1 bus.reg_rd_data = 8'($urandom);
      end
    end
  end

  // Memory: answers mem_delay cycles after the strobe cycle; also injects stray valids.
  initial begin : mem_model
    logic [31:0] ma;
    int          d;
    int          gen;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = $urandom;
      if (bus.mem_rd_en) begin
        ma  = bus.mem_rd_addr;
        d   = mem_delay;
        gen = rst_count;
        if (d < 0) begin
          repeat (20) @(negedge clk);
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = 32'h1BAD_1BAD;
        end else begin
          repeat (d) @(negedge clk);
          if (gen == rst_count) check("mem_rd_addr_held", bus.mem_rd_addr, ma);
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = mem_word(ma);
        end
      end else if (stray_req) begin
        stray_req        = 1'b0;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
      end
    end
  end

  // Response scoreboard: pops on each handshake, checks stability while stalled.
  initial begin : rsp_monitor
    rsp_t        e;
    logic        hold;
    logic [31:0] hd;
    logic        he;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        check("req_ready_while_busy", 32'(bus.req_ready), 32'd0);
        if (hold) begin
          check("rsp_data_stable", bus.rsp_data, hd);
          check("rsp_err_stable", 32'(bus.rsp_err), 32'(he));
        end
        if (bus.rsp_ready) begin
          hold = 1'b0;
          if (exp_rsp.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL rsp_unexpected: got data %h err %0b with no request pending", bus.rsp_data, bus.rsp_err);
          end else begin
            e = exp_rsp.pop_front();
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          end
        end else begin
          hold = 1'b1;
          hd   = bus.rsp_data;
          he   = bus.rsp_err;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  // Strobe scoreboard: one-cycle pulses, never overlapping, in request order.
  initial begin : strobe_monitor
    strobe_t s;
    logic    prev_reg;
    logic    prev_mem;
    prev_reg = 1'b0;
    prev_mem = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.reg_rd_en || bus.mem_rd_en) begin
        check("strobe_overlap", 32'(bus.reg_rd_en & bus.mem_rd_en), 32'd0);
        if (bus.reg_rd_en) check("reg_rd_en_pulse", 32'(prev_reg), 32'd0);
        if (bus.mem_rd_en) check("mem_rd_en_pulse", 32'(prev_mem), 32'd0);
        if (exp_strobe.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL strobe_unexpected: got reg_rd_en %0b mem_rd_en %0b with no request pending", bus.reg_rd_en, bus.mem_rd_en);
        end else begin
          s = exp_strobe.pop_front();
          check("strobe_is_reg", 32'(bus.reg_rd_en), 32'(s.is_reg));
          if (s.is_reg) check("reg_rd_addr", 32'(bus.reg_rd_addr), {24'h0, s.addr[7:0]});
          else          check("mem_rd_addr", bus.mem_rd_addr, s.addr);
        end
      end
      prev_reg = bus.reg_rd_en;
      prev_mem = bus.mem_rd_en;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  b;
    int  seen;
    bit  is_reg;

    for (int i = 0; i < 256; i++) regfile[i] = 8'($urandom);
    regfile[8'h12] = 8'hA5;
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_reg_mem = 1'b0;
    bus.req_addr    = '0;

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Register read with a stray memory valid during the transaction.
    ready_mode = 0;
    issue(1'b1, 32'h12, 0, 1'b1);
    drain();

    // Memory read answered five cycles after the strobe.
    issue(1'b0, 32'h100, 5, 1'b0);
    drain();

    // Backpressure: hold rsp_ready low, then release.
    ready_mode = 2;
    issue(1'b1, $urandom, 0, 1'b0);
    b = 0;
    while (!bus.rsp_valid && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
    end
    ready_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    check("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
    drain();

    // Reset while waiting on memory; the late memory answer must be dropped.
    issue(1'b0, 32'h2000, 30, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    rst_count++;
    exp_rsp.delete();
    exp_strobe.delete();
    #1 check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("no_rsp_after_reset", 32'(seen), 32'd0);

    // Back-to-back alternating requests.
    for (int i = 0; i < 4; i++) issue((i % 2) == 0, $urandom, 1, 1'b0);
    drain();

    // Randomised traffic with random backpressure and memory latency.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      is_reg = 1'($urandom);
      issue(is_reg, $urandom, $urandom_range(1, 6), is_reg && ($urandom_range(0, 1) == 1));
    end
    drain();

`ifdef USB_RDBK_TIMEOUT_EN
    // Memory never answers: error word, then a late valid that must be ignored.
    ready_mode = 0;
    issue(1'b0, 32'h300, -1, 1'b0);
    drain();
    repeat (25) @(negedge clk);
    issue(1'b1, 32'h12, 0, 1'b0);
    drain();
`endif

    check("final_pending", 32'(exp_rsp.size() + exp_strobe.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
